// File: rtl/midi_pkg.sv
// Shared MIDI constants and types for the sysex config-dump requester and its reply parser.
package midi_pkg;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] MFR_ID      = 8'h7D;
  localparam logic [7:0] MAGIC0      = 8'h2A;
  localparam logic [7:0] MAGIC1      = 8'h4D;
  localparam logic [7:0] CMD_REQ_CFG = 8'h00;
  localparam logic [7:0] RSP_CFG     = 8'h40;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  localparam int REQ_LEN = 6;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} req_state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
  localparam logic [1:0] ERR_MALFORMED = 2'b10;

  // Request frame F0 7D 2A 4D 00 F7, indexed by byte position.
  function automatic logic [7:0] req_byte(input logic [2:0] i);
    case (i)
      3'd0:    req_byte = SYSEX_START;
      3'd1:    req_byte = MFR_ID;
      3'd2:    req_byte = MAGIC0;
      3'd3:    req_byte = MAGIC1;
      3'd4:    req_byte = CMD_REQ_CFG;
      default: req_byte = SYSEX_END;
    endcase
  endfunction

  // Reply header bytes expected at parser index 1..3.
  function automatic logic [7:0] hdr_byte(input logic [3:0] i);
    case (i)
      4'd1:    hdr_byte = MFR_ID;
      4'd2:    hdr_byte = MAGIC0;
      default: hdr_byte = MAGIC1;
    endcase
  endfunction

endpackage

// File: rtl/midi_cfg_rsp_parser.sv
// Byte-wise parser for the config-dump reply; flags a complete or a broken frame and keeps
// the payload bytes in shadow registers until the requester commits them.
module midi_cfg_rsp_parser
  import midi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  output logic       frame_ok,
  output logic       frame_bad,
  output logic [6:0] sh_version,
  output logic [6:0] sh_n_in,
  output logic [6:0] sh_n_out,
  output logic [6:0] sh_bpm_msb,
  output logic [6:0] sh_bpm_lsb
);

  logic [3:0] idx_q, idx_d;
  logic       store;

  always_comb begin
    idx_d     = idx_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    store     = 1'b0;
    // Realtime bytes (F8..FF) fall through untouched.
    if (active && rx_dv && (rx_data < RT_MIN)) begin
      if (rx_data == SYSEX_START) begin
        idx_d = 4'd1;
      end else if (!rx_data[7]) begin
        if (idx_q == 4'd0) begin
          idx_d = 4'd0;
        end else if (idx_q <= 4'd3) begin
          idx_d = (rx_data == hdr_byte(idx_q)) ? idx_q + 4'd1 : 4'd0;
        end else if (idx_q == 4'd4) begin
          if (rx_data == RSP_CFG) idx_d = 4'd5;
          else                    frame_bad = 1'b1;
        end else if (idx_q <= 4'd9) begin
          store = 1'b1;
          idx_d = idx_q + 4'd1;
        end else begin
          frame_bad = 1'b1;
        end
      end else if ((idx_q == 4'd10) && (rx_data == SYSEX_END)) begin
        frame_ok = 1'b1;
      end else if (idx_q >= 4'd4) begin
        frame_bad = 1'b1;
      end else begin
        idx_d = 4'd0;
      end
    end
    if (frame_ok || frame_bad) idx_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst || !active) idx_q <= 4'd0;
    else                 idx_q <= idx_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_version <= 7'd0;
      sh_n_in    <= 7'd0;
      sh_n_out   <= 7'd0;
      sh_bpm_msb <= 7'd0;
      sh_bpm_lsb <= 7'd0;
    end else if (store) begin
      case (idx_q)
        4'd5:    sh_version <= rx_data[6:0];
        4'd6:    sh_n_in    <= rx_data[6:0];
        4'd7:    sh_n_out   <= rx_data[6:0];
        4'd8:    sh_bpm_msb <= rx_data[6:0];
        default: sh_bpm_lsb <= rx_data[6:0];
      endcase
    end
  end

endmodule

// File: rtl/midi_cfg_requester.sv
// Host-side initiator: sends the config-dump request over one MIDI port, waits for the reply
// with timeout and retries, and presents the decoded router configuration.
module midi_cfg_requester
  import midi_pkg::*;
#(
  parameter int CLOCK       = 12_000_000,
  parameter int TIMEOUT_CYC = CLOCK / 10,
  parameter int RETRIES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        cfg_valid,
  output logic [6:0]  version,
  output logic [6:0]  n_in,
  output logic [6:0]  n_out,
  output logic [13:0] bpm,
  output req_state_t  dbg_state
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  req_state_t    state_q, state_d;
  logic [2:0]    tx_idx_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    retry_q;
  logic          done_q, err_q, cfg_valid_q;
  logic [1:0]    err_code_q;
  logic [6:0]    version_q, n_in_q, n_out_q, bpm_msb_q, bpm_lsb_q;

  logic       frame_ok, frame_bad;
  logic [6:0] sh_version, sh_n_in, sh_n_out, sh_bpm_msb, sh_bpm_lsb;
  logic       in_wait, start_acc, tx_fire, tx_last, tmo_hit, do_retry, do_fail;

  // tx handshake: a byte moves when tx_valid & tx_ready at posedge clk; while tx_ready is low
  // tx_valid and tx_data hold, and only reset can drop tx_valid before the byte moves.
  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? req_byte(tx_idx_q) : 8'h00;
  assign tx_fire  = tx_valid && tx_ready;
  assign tx_last  = tx_fire && (tx_idx_q == 3'(REQ_LEN - 1));

  // A start landing on the done/err cycle is dropped along with starts while busy.
  assign in_wait   = (state_q == WAIT);
  assign start_acc = (state_q == IDLE) && start && !done_q && !err_q;
  assign tmo_hit   = in_wait && !frame_ok && !frame_bad && (tmo_q == '0);
  assign do_retry  = tmo_hit && (retry_q < 8'(RETRIES));
  assign do_fail   = tmo_hit && !do_retry;

  midi_cfg_rsp_parser u_parser (
    .clk        (clk),
    .rst        (rst),
    .active     (in_wait),
    .rx_data    (rx_data),
    .rx_dv      (rx_dv),
    .frame_ok   (frame_ok),
    .frame_bad  (frame_bad),
    .sh_version (sh_version),
    .sh_n_in    (sh_n_in),
    .sh_n_out   (sh_n_out),
    .sh_bpm_msb (sh_bpm_msb),
    .sh_bpm_lsb (sh_bpm_lsb)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = SEND;
      SEND:    if (tx_last) state_d = WAIT;
      WAIT: begin
        if (frame_ok || frame_bad || do_fail) state_d = IDLE;
        else if (do_retry)                    state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_idx_q    <= 3'd0;
      tmo_q       <= '0;
      retry_q     <= 8'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      cfg_valid_q <= 1'b0;
      version_q   <= 7'd0;
      n_in_q      <= 7'd0;
      n_out_q     <= 7'd0;
      bpm_msb_q   <= 7'd0;
      bpm_lsb_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      done_q  <= frame_ok;
      err_q   <= frame_bad || do_fail;
      if (start_acc) begin
        tx_idx_q    <= 3'd0;
        retry_q     <= 8'd0;
        cfg_valid_q <= 1'b0;
        err_code_q  <= ERR_NONE;
      end
      if (tx_fire) tx_idx_q <= tx_last ? 3'd0 : tx_idx_q + 3'd1;
      // The reply window opens when the final request byte leaves.
      if (tx_last)                     tmo_q <= TW'(TIMEOUT_CYC);
      else if (in_wait && tmo_q != '0) tmo_q <= tmo_q - TW'(1);
      if (do_retry) retry_q <= retry_q + 8'd1;
      if (frame_ok) begin
        cfg_valid_q <= 1'b1;
        version_q   <= sh_version;
        n_in_q      <= sh_n_in;
        n_out_q     <= sh_n_out;
        bpm_msb_q   <= sh_bpm_msb;
        bpm_lsb_q   <= sh_bpm_lsb;
      end
      if (frame_bad)    err_code_q <= ERR_MALFORMED;
      else if (do_fail) err_code_q <= ERR_TIMEOUT;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign cfg_valid = cfg_valid_q;
  assign version   = version_q;
  assign n_in      = n_in_q;
  assign n_out     = n_out_q;
  assign bpm       = {bpm_msb_q, bpm_lsb_q};
  assign dbg_state = state_q;

endmodule
